// File: rtl/shift_frame_ctrl_pkg.sv
// Shared types and constants for the framed serial shift controller.
package shift_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic DIR_RIGHT = 1'b0;  // LSB first
    localparam logic DIR_LEFT  = 1'b1;  // MSB first

    // Width of the inter-frame gap counter; never narrower than one bit.
    function automatic int gap_cnt_width(input int gap);
        if (gap > 1) begin
            return $clog2(gap);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/shift_frame_ctrl_if.sv
// Word-load handshake between a producer and the shift frame controller.
interface shift_frame_ctrl_if #(
    parameter int N = 4
);
    logic [N-1:0] load_data;
    logic         load_dir;
    logic         load_valid;
    logic         load_ready;

    modport master (output load_data, output load_dir, output load_valid, input load_ready);
    modport slave  (input load_data, input load_dir, input load_valid, output load_ready);
endinterface

// File: rtl/shift_frame_ctrl_piso_shift_reg.sv
// Loadable bidirectional parallel-in / serial-out shift register.
module piso_shift_reg
    import shift_ctrl_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift,
    input  logic         clear,
    input  logic         dir,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    logic [N-1:0] sreg_r;

    // Shift register: clear beats load, load beats shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_r <= '0;
        end else if (clear) begin
            sreg_r <= '0;
        end else if (load) begin
            sreg_r <= d;
        end else if (shift) begin
            if (dir == DIR_LEFT) begin
                sreg_r <= {sreg_r[N-2:0], 1'b0};
            end else begin
                sreg_r <= {1'b0, sreg_r[N-1:1]};
            end
        end else begin
            sreg_r <= sreg_r;
        end
    end

    assign q = sreg_r;

endmodule

// File: rtl/shift_frame_ctrl.sv
// Framed serial transmitter controller: accepts words, sequences the shift
// register, produces frame strobes, done pulse and a completed-frame count.
module shift_frame_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int   N        = 4,
    parameter int   GAP      = 1,
    parameter logic IDLE_LVL = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    shift_frame_ctrl_if.slave   ld,
    input  logic                abort,
    output logic                serial_out,
    output logic                shift_en,
    output logic                frame_start,
    output logic                bit_last,
    output logic                done,
    output logic                busy,
    output logic [7:0]          frame_cnt
);

    localparam int            CW       = $clog2(N);
    localparam int            GW       = gap_cnt_width(GAP);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? (GAP - 1) : 0);
    localparam logic          GAP_EN   = (GAP > 0);

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r;
    logic [GW-1:0] gap_cnt_r;
    logic          dir_r;
    logic          done_r;
    logic [7:0]    frame_cnt_r;
    logic [N-1:0]  sreg_s;
    logic          ready_s;
    logic          accept_s;
    logic          last_s;
    logic          kill_s;

    assign last_s = (state_r == ST_SHIFT) && (cnt_r == CNT_LAST);
    assign kill_s = abort && (state_r != ST_IDLE);

    // Handshake and next-state decode; abort overrides everything else.
    always_comb begin
        state_s  = state_r;
        ready_s  = 1'b0;
        accept_s = 1'b0;
        if ((state_r == ST_IDLE) || (last_s && !GAP_EN)) begin
            ready_s = !abort;
        end else begin
            ready_s = 1'b0;
        end
        accept_s = ld.load_valid && ready_s;
        if (kill_s) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_s = ST_SHIFT;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (!last_s || accept_s) begin
                        state_s = ST_SHIFT;
                    end else if (GAP_EN) begin
                        state_s = ST_GAP;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_r == GAP_LAST) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_GAP;
                    end
                end
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Bit counter and captured direction for the frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
            dir_r <= DIR_RIGHT;
        end else if (kill_s || accept_s) begin
            cnt_r <= '0;
            dir_r <= accept_s ? ld.load_dir : dir_r;
        end else if (state_r == ST_SHIFT) begin
            cnt_r <= last_s ? '0 : (cnt_r + {{(CW-1){1'b0}}, 1'b1});
            dir_r <= dir_r;
        end else begin
            cnt_r <= cnt_r;
            dir_r <= dir_r;
        end
    end

    // Inter-frame gap counter, runs only while in the gap state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt_r <= '0;
        end else if (!kill_s && (state_r == ST_GAP) && (gap_cnt_r != GAP_LAST)) begin
            gap_cnt_r <= gap_cnt_r + {{(GW-1){1'b0}}, 1'b1};
        end else begin
            gap_cnt_r <= '0;
        end
    end

    // Completion pulse and frame count; an aborted last bit does not complete.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_r      <= 1'b0;
            frame_cnt_r <= 8'd0;
        end else if (last_s && !abort) begin
            done_r      <= 1'b1;
            frame_cnt_r <= frame_cnt_r + 8'd1;
        end else begin
            done_r      <= 1'b0;
            frame_cnt_r <= frame_cnt_r;
        end
    end

    piso_shift_reg #(.N(N)) u_sreg (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept_s),
        .shift (state_r == ST_SHIFT),
        .clear (kill_s),
        .dir   (dir_r),
        .d     (ld.load_data),
        .q     (sreg_s)
    );

    assign ld.load_ready = ready_s;
    assign shift_en      = (state_r == ST_SHIFT);
    assign frame_start   = (state_r == ST_SHIFT) && (cnt_r == '0);
    assign bit_last      = last_s;
    assign busy          = (state_r != ST_IDLE);
    assign done          = done_r;
    assign frame_cnt     = frame_cnt_r;
    assign serial_out    = (state_r == ST_SHIFT) ?
                           ((dir_r == DIR_LEFT) ? sreg_s[N-1] : sreg_s[0]) : IDLE_LVL;

endmodule
